// File: rtl/survivor_mem_if.sv
// Survivor memory bus: ACS row write port, lock, status and traceback read port.
interface survivor_mem_if #(
   parameter int M = 6,
   parameter int D = 40
) ();
   localparam int S  = 1 << M;
   localparam int PW = $clog2(D);
   localparam int CW = $clog2(D + 1);

   logic          in_valid;
   logic          in_ready;
   logic [S-1:0]  in_row;
   logic          lock;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] fill;
   logic          full;
   logic [PW-1:0] tb_time;
   logic [M-1:0]  tb_state;
   logic          tb_surv_bit;

   // Producer / traceback side
   modport master (
      output in_valid, in_row, lock, tb_time, tb_state,
      input  in_ready, wr_ptr, fill, full, tb_surv_bit
   );

   // Survivor memory side
   modport slave (
      input  in_valid, in_row, lock, tb_time, tb_state,
      output in_ready, wr_ptr, fill, full, tb_surv_bit
   );
endinterface

// File: rtl/survivor_mem.sv
// Circular survivor-bit store: one row of 2^M decision bits per trellis step,
// D rows deep, single-bit registered read by (time, state) for traceback.
module survivor_mem #(
   parameter int M = 6,
   parameter int D = 40
) (
   input logic           clk,
   input logic           rst,
   survivor_mem_if.slave bus
);
   localparam int S  = 1 << M;
   localparam int PW = $clog2(D);
   localparam int CW = $clog2(D + 1);

   localparam logic [PW-1:0] LAST_ROW = PW'(D - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(D);
   localparam logic [PW:0]   DEPTH    = (PW + 1)'(D);

   // Row storage, deliberately without reset so it maps onto block RAM;
   // rv_reg decides whether a row's contents may be trusted.
   logic [S-1:0]  mem [D];

   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] wr_ptr_next;
   logic [CW-1:0] fill_reg;
   logic [CW-1:0] fill_next;
   logic          full_reg;
   logic [D-1:0]  rv_reg;
   logic [D-1:0]  wr_sel;
   logic          wr_en;
   logic          rd_in_range;
   logic [PW-1:0] rd_addr;
   logic          rd_ok_reg;
   logic          rd_bit_reg;

   assign bus.in_ready = ~bus.lock;
   assign wr_en        = bus.in_valid & ~bus.lock;

   assign wr_ptr_next = (wr_ptr_reg == LAST_ROW) ? '0 : wr_ptr_reg + 1'b1;
   assign fill_next   = (fill_reg == FULL_CNT) ? fill_reg : fill_reg + 1'b1;

   // Out-of-range addresses are steered to row 0 so the array is never
   // indexed past its end; the range flag forces the result to 0 anyway.
   assign rd_in_range = ({1'b0, bus.tb_time} < DEPTH);
   assign rd_addr     = rd_in_range ? bus.tb_time : '0;

   // One-hot decode of the row the next accepted write will land in.
   genvar gi;
   generate
      for (gi = 0; gi < D; gi = gi + 1) begin : g_wr_sel
         assign wr_sel[gi] = (wr_ptr_next == PW'(gi));
      end
   endgenerate

   // Pointer, fill count, full flag, row-valid vector and read-valid flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= LAST_ROW;
         fill_reg   <= '0;
         full_reg   <= 1'b0;
         rv_reg     <= '0;
         rd_ok_reg  <= 1'b0;
      end else begin
         // rv_reg is sampled before its update: a same-edge write to the
         // row being read still reports the row's previous validity.
         rd_ok_reg <= rd_in_range & rv_reg[rd_addr];
         if (wr_en) begin
            wr_ptr_reg <= wr_ptr_next;
            fill_reg   <= fill_next;
            rv_reg     <= rv_reg | wr_sel;
            if (fill_reg == FULL_CNT - 1'b1)
               full_reg <= 1'b1;
         end
      end
   end

   // Array write and registered bit read; non-blocking order gives
   // read-before-write on a shared row.
   always_ff @(posedge clk) begin
      if (wr_en && !rst)
         mem[wr_ptr_next] <= bus.in_row;
      rd_bit_reg <= mem[rd_addr][bus.tb_state];
   end

   assign bus.tb_surv_bit = rd_bit_reg & rd_ok_reg;
   assign bus.wr_ptr      = wr_ptr_reg;
   assign bus.fill        = fill_reg;
   assign bus.full        = full_reg;
endmodule

// File: tb/tb_survivor_mem.sv
// Self-checking bench for survivor_mem: directed scenarios plus random
// traffic, checked against a write-history model of the store.
module tb_survivor_mem;
   localparam int M = 6;
   localparam int D = 40;
   localparam int S = 1 << M;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   survivor_mem_if #(.M(M), .D(D)) bus ();

   survivor_mem #(.M(M), .D(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Every accepted row since the last reset, in order of acceptance.
   logic [S-1:0] hist [$];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Row t holds the most recent write whose sequence number is t mod D.
   function automatic logic model_bit(input int t, input int s);
      int n;
      int k;
      n = hist.size();
      if (t >= D || n <= t)
         return 1'b0;
      k = t + D * ((n - 1 - t) / D);
      return hist[k][s];
   endfunction

   function automatic int model_ptr();
      int n;
      n = hist.size();
      return (n == 0) ? D - 1 : (n - 1) % D;
   endfunction

   function automatic int model_fill();
      return (hist.size() < D) ? hist.size() : D;
   endfunction

   task automatic check_state(input string tag);
      check({tag, ":wr_ptr"}, 64'(bus.wr_ptr), 64'(model_ptr()));
      check({tag, ":fill"},   64'(bus.fill),   64'(model_fill()));
      check({tag, ":full"},   64'(bus.full),   64'(hist.size() >= D));
   endtask

   // One clock cycle: drive inputs, predict the read, clock, compare.
   task automatic step(input string tag, input logic v, input logic [S-1:0] row,
                       input logic lk, input int t, input int s);
      logic exp_rd;
      bus.in_valid = v;
      bus.in_row   = row;
      bus.lock     = lk;
      bus.tb_time  = 6'(t);
      bus.tb_state = 6'(s);
      #1;
      check({tag, ":in_ready"}, 64'(bus.in_ready), 64'(!lk));
      exp_rd = model_bit(t, s);
      @(posedge clk);
      if (v && !lk)
         hist.push_back(row);
      #1;
      check({tag, ":rd"}, 64'(bus.tb_surv_bit), 64'(exp_rd));
      check_state(tag);
      $display("%s t=%0t valid=%0b lock=%0b row=%h rd(%0d,%0d)=%0b wr_ptr=%0d fill=%0d full=%0b",
               tag, $time, v, lk, row, t, s, bus.tb_surv_bit, bus.wr_ptr, bus.fill, bus.full);
   endtask

   // Raise rst between edges; outputs must clear before the next edge.
   task automatic async_reset(input string tag);
      @(negedge clk);
      #2;
      rst = 1'b1;
      hist.delete();
      #1;
      check_state(tag);
      check({tag, ":rd"}, 64'(bus.tb_surv_bit), 64'd0);
      $display("%s t=%0t async reset wr_ptr=%0d fill=%0d full=%0b",
               tag, $time, bus.wr_ptr, bus.fill, bus.full);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [S-1:0] held;
      bus.in_valid = 1'b0;
      bus.in_row   = '0;
      bus.lock     = 1'b0;
      bus.tb_time  = '0;
      bus.tb_state = '0;

      // Power-on reset
      repeat (2) @(negedge clk);
      check("por:rd", 64'(bus.tb_surv_bit), 64'd0);
      check_state("por");
      rst = 1'b0;
      step("por_read", 1'b0, '0, 1'b0, 7, 3);

      // Three small rows, then targeted reads
      step("w3", 1'b1, 64'h1, 1'b0, 0, 0);
      step("w3", 1'b1, 64'h2, 1'b0, 0, 0);
      step("w3", 1'b1, 64'h4, 1'b0, 0, 0);
      step("rd_1_1", 1'b0, '0, 1'b0, 1, 1);
      step("rd_1_0", 1'b0, '0, 1'b0, 1, 0);
      step("rd_5_0", 1'b0, '0, 1'b0, 5, 0);

      // Fill all D rows, then wrap
      async_reset("rst_fill");
      for (int k = 0; k < D; k++)
         step("fill", 1'b1, 64'h1 << k, 1'b0, k % 45, k % S);
      step("wrap", 1'b1, {S{1'b1}}, 1'b0, 0, 63);
      step("rd_0_63", 1'b0, '0, 1'b0, 0, 63);
      for (int t = D; t < 64; t += 7)
         step("oor", 1'b0, '0, 1'b0, t, t % S);

      // Lock holds off writes; producer keeps its row presented
      held = {$urandom, $urandom};
      for (int i = 0; i < 10; i++)
         step("locked", 1'b1, held, 1'b1, i, i);
      step("unlock", 1'b1, held, 1'b0, 1, 0);

      // Same-edge write and read of row 5
      async_reset("rst_rbw");
      for (int k = 0; k < 5; k++)
         step("pre5", 1'b1, {$urandom, $urandom}, 1'b0, k, 0);
      step("rbw_old", 1'b1, {S{1'b1}}, 1'b0, 5, 7);
      step("rbw_new", 1'b0, '0, 1'b0, 5, 7);

      // Random traffic, including lock and out-of-range reads
      for (int i = 0; i < 300; i++)
         step("rand", 1'($urandom_range(0, 3) != 0), {$urandom, $urandom},
              1'($urandom_range(0, 3) == 0), $urandom_range(0, 63), $urandom_range(0, 63));

      // Reset in the middle of operation
      async_reset("rst_mid");
      for (int k = 0; k < 20; k++)
         step("mid", 1'b1, {$urandom, $urandom} | 64'hF, 1'b0, k, 0);
      async_reset("rst_mid2");
      step("mid_rd3", 1'b0, '0, 1'b0, 3, 0);
      step("mid_rd3", 1'b0, '0, 1'b0, 3, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
